alu_op_sequencer: RTL and testbench

- Upstream/downstream wrapper stage around the 4-bit combinational ALU.
- Collects operand A, operand B and the 2-bit ALUControl code one at a time over a valid/ready input stream.
- Drives the ALU with registered, stable operands, samples its result, generates NZCV flags, and presents result plus flags on a valid/ready output.
- Sits between the board/test input logic and the ALU.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_flag_gen.sv | 34 +++
 rtl/alu_op_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer and its flag generator.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV generator: N/Z come from the ALU result, C/V from a local
// (WIDTH+1)-bit recomputation of the add/subtract on the registered operands.
module alu_flag_gen
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_arith;

  always_comb begin
    w_arith = (control == OP_ADD) || (control == OP_SUB);
    // Subtract is a + ~b + 1, so the carry out means "no borrow".
    w_b_eff = (control == OP_SUB) ? ~b : b;
    w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, (control == OP_SUB)};

    nzcv         = '0;
    nzcv[FLAG_N] = result[WIDTH-1];
    nzcv[FLAG_Z] = (result == '0);
    if (w_arith) begin
      nzcv[FLAG_C] = w_sum[WIDTH];
      nzcv[FLAG_V] = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Serial A/B/opcode loader that drives an external combinational ALU and returns
// result plus NZCV over valid/ready. `ALU_OP_SEQUENCER_ACCUM_EN chains the result into A.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           r_state;
  state_t           w_next;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_in_ready_d;
  logic             w_out_valid_d;
  logic             w_in_xfer;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_control;
  logic [WIDTH-1:0] r_out_result;
  logic [3:0]       r_out_flags;
  logic [3:0]       w_flags;

  assign w_in_xfer = in_valid && r_in_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD_A;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD_A:  if (w_in_xfer) w_next = LOAD_B;
      LOAD_B:  if (w_in_xfer) w_next = LOAD_OP;
      LOAD_OP: if (w_in_xfer) w_next = EXEC;
      EXEC:    w_next = DONE;
      DONE: begin
        if (out_ready) begin
`ifdef ALU_OP_SEQUENCER_ACCUM_EN
          w_next = LOAD_B;
`else
          w_next = LOAD_A;
`endif
        end
      end
      default: w_next = LOAD_A;
    endcase
  end

  // Handshake outputs are registered from the next state so in_ready stays low
  // through reset and rises one cycle after it releases.
  always_comb begin
    w_in_ready_d  = (w_next == LOAD_A) || (w_next == LOAD_B) || (w_next == LOAD_OP);
    w_out_valid_d = (w_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_d;
      r_out_valid <= w_out_valid_d;
    end
  end

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .a       (r_alu_a),
    .b       (r_alu_b),
    .control (r_alu_control),
    .result  (alu_result),
    .nzcv    (w_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_control <= '0;
      r_out_result  <= '0;
      r_out_flags   <= '0;
    end else begin
      if (r_state == LOAD_A && w_in_xfer)  r_alu_a       <= in_data;
      if (r_state == LOAD_B && w_in_xfer)  r_alu_b       <= in_data;
      if (r_state == LOAD_OP && w_in_xfer) r_alu_control <= in_data[1:0];
      if (r_state == EXEC) begin
        r_out_result <= alu_result;
        r_out_flags  <= w_flags;
      end
`ifdef ALU_OP_SEQUENCER_ACCUM_EN
      if (r_state == DONE && out_ready) r_alu_a <= r_out_result;
`endif
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_control = r_alu_control;
  assign out_result  = r_out_result;
  assign out_flags   = r_out_flags;

`ifndef SYNTHESIS
  logic [WIDTH-1:0] w_chk_sum;
  assign w_chk_sum = (r_alu_control == OP_SUB) ? (r_alu_a + ~r_alu_b + {{(WIDTH-1){1'b0}}, 1'b1})
                                               : (r_alu_a + r_alu_b);
  a_alu_sum_match: assert property (@(posedge clk) disable iff (rst)
    (r_state == EXEC && !r_alu_control[1]) |-> (alu_result == w_chk_sum));
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer with an integer-arithmetic
// reference model and a behavioural ALU on the alu_* interface.
module tb_alu_op_sequencer;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic             out_valid;
  logic             out_ready;

  int               n_vec = 0;
  int               n_err = 0;
  logic             need_a;
  logic [3:0]       acc;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Behavioural combinational ALU
  always_comb begin
    alu_result = alu_a | alu_b;
    case (alu_control)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  // Reference: unsigned integer sum for result/carry, signed integer sum for overflow
  function automatic void ref_op(input int a, input int b, input int op,
                                 output logic [3:0] r, output logic [3:0] f);
    int sa, sb, u, s;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    s  = 0;
    case (op)
      0:       begin u = a + b;            s = sa + sb; end
      1:       begin u = a + (15 - b) + 1; s = sa - sb; end
      2:       u = a & b;
      default: u = a | b;
    endcase
    r    = u[3:0];
    f[3] = r[3];
    f[2] = (r == 4'h0);
    f[1] = (op < 2) && (u >= 16);
    f[0] = (op < 2) && ((s > 7) || (s < -8));
  endfunction

  task automatic send_word(input logic [3:0] w, input string tag);
    int t;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
    in_data  = w;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready_timeout in_ready=%b required 1", tag, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 4'($urandom);
  endtask

  task automatic send_op(input logic [3:0] a, input logic [3:0] b, input int op, input int hold);
    logic [3:0] ea, er, ef, opw;
    logic [1:0] opc;
    opc = 2'(op);
    ea  = need_a ? a : acc;
    if (need_a) send_word(a, "a");
    send_word(b, "b");
    opw = {2'($urandom), opc};
    send_word(opw, "op");
    ref_op(int'(ea), int'(b), op, er, ef);

    n_vec++;
    if ({out_valid, in_ready, alu_a, alu_b, alu_control} !== {1'b0, 1'b0, ea, b, opc}) begin
      n_err++;
      $display("FAIL exec_operands got v=%b rdy=%b a=%h b=%h c=%b required v=0 rdy=0 a=%h b=%h c=%b",
               out_valid, in_ready, alu_a, alu_b, alu_control, ea, b, opc);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_result, out_flags} !== {1'b1, er, ef}) begin
      n_err++;
      $display("FAIL result a=%h b=%h op=%0d got v=%b r=%h f=%b required v=1 r=%h f=%b",
               ea, b, op, out_valid, out_result, out_flags, er, ef);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 4'($urandom);
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, in_ready, out_result, out_flags, alu_a, alu_b} !== {1'b1, 1'b0, er, ef, ea, b}) begin
        n_err++;
        $display("FAIL hold_%0d got v=%b rdy=%b r=%h f=%b a=%h b=%h required v=1 rdy=0 r=%h f=%b a=%h b=%h",
                 i, out_valid, in_ready, out_result, out_flags, alu_a, alu_b, er, ef, ea, b);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL release got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
    end
`ifdef ALU_OP_SEQUENCER_ACCUM_EN
    need_a = 1'b0;
    acc    = er;
    n_vec++;
    if (alu_a !== er) begin
      n_err++;
      $display("FAIL accum_chain alu_a=%h required %h", alu_a, er);
    end
`endif
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({in_ready, out_valid, alu_a, alu_b, alu_control, out_result, out_flags} !== '0) begin
      n_err++;
      $display("FAIL reset_state got rdy=%b v=%b a=%h b=%h c=%b r=%h f=%b required all 0",
               in_ready, out_valid, alu_a, alu_b, alu_control, out_result, out_flags);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release in_ready=%b required 1", in_ready);
    end
    need_a = 1'b1;
    acc    = '0;
  endtask

  task automatic test_directed();
    logic [3:0] tv_a [5] = '{4'h5, 4'h3, 4'h5, 4'hC, 4'hC};
    logic [3:0] tv_b [5] = '{4'h3, 4'h5, 4'h5, 4'hA, 4'hA};
    int         tv_op[5] = '{0, 1, 1, 2, 3};
    logic [3:0] tv_r [5] = '{4'h8, 4'hE, 4'h0, 4'h8, 4'hE};
    logic [3:0] tv_f [5] = '{4'b1001, 4'b1000, 4'b0110, 4'b1000, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      send_op(tv_a[i], tv_b[i], tv_op[i], 0);
      n_vec++;
      if ({out_result, out_flags} !== {tv_r[i], tv_f[i]}) begin
        n_err++;
        $display("FAIL directed_%0d got r=%h f=%b required r=%h f=%b",
                 i, out_result, out_flags, tv_r[i], tv_f[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    send_op(4'h9, 4'h4, 0, 3);
    send_op(4'h7, 4'h1, 1, 2);
  endtask

  task automatic test_reset_mid();
    if (need_a) send_word(4'h9, "mid_a");
    send_word(4'h6, "mid_b");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({in_ready, out_valid, alu_a, alu_b, alu_control, out_result, out_flags} !== '0) begin
      n_err++;
      $display("FAIL reset_mid got rdy=%b v=%b a=%h b=%h c=%b r=%h f=%b required all 0",
               in_ready, out_valid, alu_a, alu_b, alu_control, out_result, out_flags);
    end
    @(posedge clk); #1;
    need_a = 1'b1;
    acc    = '0;
    send_word(4'h7, "post_rst");
    n_vec++;
    if ({alu_a, alu_b, alu_control} !== {4'h7, 4'h0, 2'b00}) begin
      n_err++;
      $display("FAIL reset_mid_reload got a=%h b=%h c=%b required a=7 b=0 c=00",
               alu_a, alu_b, alu_control);
    end
    test_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      send_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
  endtask

  task automatic test_accum();
    test_reset();
    send_op(4'h1, 4'h2, 0, 0);
    n_vec++;
    if (out_result !== 4'h3) begin
      n_err++;
      $display("FAIL accum_first out_result=%h required 3", out_result);
    end
    send_op(4'h0, 4'h4, 0, 0);
    n_vec++;
    if (out_result !== 4'h7) begin
      n_err++;
      $display("FAIL accum_second out_result=%h required 7", out_result);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef ALU_OP_SEQUENCER_ACCUM_EN
    test_accum();
`else
    test_directed();
`endif
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
